// File: rtl/shift_rotate_if.sv
// Handshake and operand/result bundle for the iterative shift/rotate unit.
interface shift_rotate_if #(
    parameter int WIDTH = 16
);
    localparam int AW = $clog2(WIDTH);

    logic             enable;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    amount;
    logic [WIDTH-1:0] result;
    logic             cf;
    logic             zf;
    logic             nf;
    logic             busy;
    logic             done;

    modport master (
        output enable, start, mode, data_in, amount,
        input  result, cf, zf, nf, busy, done
    );

    modport slave (
        input  enable, start, mode, data_in, amount,
        output result, cf, zf, nf, busy, done
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// Iterative shift/rotate unit: up to STEP bit positions per enabled clock,
// start/busy/done handshake, cf/zf/nf flags published when the operation completes.
module shift_rotate_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input logic           clock,
    input logic           reset,
    shift_rotate_if.slave bus
);
    localparam int AW = $clog2(WIDTH);
    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [2:0] {M_SLL, M_SRL, M_SRA, M_ROL, M_ROR} op_t;

    state_t           state;
    op_t              op;
    logic [WIDTH-1:0] work;
    logic [AW-1:0]    remaining;
    logic [WIDTH-1:0] result;
    logic             cf, zf, nf, busy, done;

    logic [AW-1:0]    step_n;
    logic [WIDTH-1:0] nxt;
    logic             nxt_c;

    // One pass = up to STEP single-bit moves; the final move leaves its bit in nxt_c.
    always_comb begin
        step_n = (remaining > STEP_W) ? STEP_W : remaining;
        nxt    = work;
        nxt_c  = 1'b0;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (AW'(i) < step_n) begin
                case (op)
                    M_SLL: begin nxt_c = nxt[WIDTH-1]; nxt = {nxt[WIDTH-2:0], 1'b0}; end
                    M_SRL: begin nxt_c = nxt[0]; nxt = {1'b0, nxt[WIDTH-1:1]}; end
                    M_SRA: begin nxt_c = nxt[0]; nxt = {nxt[WIDTH-1], nxt[WIDTH-1:1]}; end
                    M_ROL: begin nxt_c = nxt[WIDTH-1]; nxt = {nxt[WIDTH-2:0], nxt[WIDTH-1]}; end
                    M_ROR: begin nxt_c = nxt[0]; nxt = {nxt[0], nxt[WIDTH-1:1]}; end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= M_SLL;
            work      <= '0;
            remaining <= '0;
            result    <= '0;
            cf        <= 1'b0;
            zf        <= 1'b0;
            nf        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (bus.enable) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.mode <= 3'd4 && bus.amount != '0) begin
                            work      <= bus.data_in;
                            op        <= op_t'(bus.mode);
                            remaining <= bus.amount;
                            busy      <= 1'b1;
                            state     <= SHIFT;
                        end else begin
                            // Zero count or reserved mode: pass operand straight through.
                            result <= bus.data_in;
                            cf     <= 1'b0;
                            zf     <= (bus.data_in == '0);
                            nf     <= bus.data_in[WIDTH-1];
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work      <= nxt;
                    remaining <= remaining - step_n;
                    if (remaining == step_n) begin
                        result <= nxt;
                        cf     <= nxt_c;
                        zf     <= (nxt == '0);
                        nf     <= nxt[WIDTH-1];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result;
    assign bus.cf     = cf;
    assign bus.zf     = zf;
    assign bus.nf     = nf;
    assign bus.busy   = busy;
    assign bus.done   = done;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Scoreboard bench: STEP=1 and STEP=4 units share one stimulus stream, each checked for
// result, flags and start-to-done latency against an independent whole-operation model.
module tb_shift_rotate_unit;
    typedef struct {
        logic [15:0] res;
        logic        cf;
        logic        zf;
        logic        nf;
        int          lat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mode = '0;
    logic [15:0] data_in = '0;
    logic [3:0]  amount = '0;

    int checks = 0;
    int failures = 0;
    exp_t q1[$];
    exp_t q4[$];

    shift_rotate_if #(.WIDTH(16)) bus1 ();
    shift_rotate_if #(.WIDTH(16)) bus4 ();

    assign bus1.enable  = enable;
    assign bus1.start   = start;
    assign bus1.mode    = mode;
    assign bus1.data_in = data_in;
    assign bus1.amount  = amount;
    assign bus4.enable  = enable;
    assign bus4.start   = start;
    assign bus4.mode    = mode;
    assign bus4.data_in = data_in;
    assign bus4.amount  = amount;

    shift_rotate_unit #(.WIDTH(16), .STEP(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    shift_rotate_unit #(.WIDTH(16), .STEP(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4));

    always #5 clock = ~clock;

    function automatic exp_t model(input logic [2:0] m, input logic [15:0] d, input int a,
                                   input int step);
        exp_t e;
        if (m > 3'd4 || a == 0) begin
            e.res = d;
            e.cf  = 1'b0;
            e.lat = 1;
        end else begin
            case (m)
                3'd0:    begin e.res = d << a; e.cf = d[16-a]; end
                3'd1:    begin e.res = d >> a; e.cf = d[a-1]; end
                3'd2:    begin e.res = 16'($signed(d) >>> a); e.cf = d[a-1]; end
                3'd3:    begin e.res = (d << a) | (d >> (16 - a)); e.cf = d[16-a]; end
                default: begin e.res = (d >> a) | (d << (16 - a)); e.cf = d[a-1]; end
            endcase
            e.lat = (a + step - 1) / step + 1;
        end
        e.zf = (e.res == 16'h0000);
        e.nf = e.res[15];
        return e;
    endfunction

    task automatic run(input logic [2:0] m, input logic [15:0] d, input int a);
        exp_t e;
        int   edges;
        bit   seen1, seen4;
        q1.push_back(model(m, d, a, 1));
        q4.push_back(model(m, d, a, 4));
        @(negedge clock);
        start = 1'b1; mode = m; data_in = d; amount = 4'(a);
        @(posedge clock);
        edges = 1; seen1 = 0; seen4 = 0;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (bus1.busy !== (m <= 3'd4 && a != 0 && q1[0].lat > 1)) begin
            failures++;
            $display("FAIL busy_after_accept got=%b exp=%b", bus1.busy, !bus1.busy);
        end
        forever begin
            if (!seen1 && bus1.done === 1'b1) begin
                seen1 = 1; e = q1.pop_front();
                checks++;
                if ({bus1.result, bus1.cf, bus1.zf, bus1.nf} !== {e.res, e.cf, e.zf, e.nf} || edges != e.lat) begin
                    failures++;
                    $display("FAIL step1 m=%0d d=%h a=%0d got=%h/%b%b%b lat=%0d exp=%h/%b%b%b lat=%0d",
                             m, d, a, bus1.result, bus1.cf, bus1.zf, bus1.nf, edges,
                             e.res, e.cf, e.zf, e.nf, e.lat);
                end
            end
            if (!seen4 && bus4.done === 1'b1) begin
                seen4 = 1; e = q4.pop_front();
                checks++;
                if ({bus4.result, bus4.cf, bus4.zf, bus4.nf} !== {e.res, e.cf, e.zf, e.nf} || edges != e.lat) begin
                    failures++;
                    $display("FAIL step4 m=%0d d=%h a=%0d got=%h/%b%b%b lat=%0d exp=%h/%b%b%b lat=%0d",
                             m, d, a, bus4.result, bus4.cf, bus4.zf, bus4.nf, edges,
                             e.res, e.cf, e.zf, e.nf, e.lat);
                end
            end
            if (seen1 && seen4) break;
            if (edges >= 40) begin
                checks++; failures++;
                $display("FAIL done_timeout got=%b%b exp=11", seen1, seen4);
                if (!seen1) void'(q1.pop_front());
                if (!seen4) void'(q4.pop_front());
                break;
            end
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus1.result, bus1.cf, bus1.zf, bus1.nf, bus1.busy, bus1.done,
             bus4.result, bus4.cf, bus4.zf, bus4.nf, bus4.busy, bus4.done} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h/%b%b%b%b%b exp=0", bus1.result, bus1.cf,
                     bus1.zf, bus1.nf, bus1.busy, bus1.done);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        run(3'd4, 16'hABCD, 4);
        checks++;
        if ({bus1.result, bus1.cf, bus1.nf, bus1.zf} !== {16'hDABC, 3'b110}) begin
            failures++;
            $display("FAIL ror_abcd got=%h/%b%b%b exp=dabc/110", bus1.result, bus1.cf, bus1.nf, bus1.zf);
        end
        run(3'd2, 16'h8000, 15);
        checks++;
        if ({bus1.result, bus1.cf, bus1.nf} !== {16'hFFFF, 2'b01}) begin
            failures++;
            $display("FAIL sra_8000 got=%h/%b%b exp=ffff/01", bus1.result, bus1.cf, bus1.nf);
        end
        run(3'd1, 16'h8000, 15);
        checks++;
        if ({bus1.result, bus1.cf} !== {16'h0001, 1'b0}) begin
            failures++;
            $display("FAIL srl_8000 got=%h/%b exp=0001/0", bus1.result, bus1.cf);
        end
        run(3'd0, 16'h0001, 15);
        checks++;
        if ({bus4.result, bus4.cf, bus4.nf} !== {16'h8000, 2'b01}) begin
            failures++;
            $display("FAIL sll_step4 got=%h/%b%b exp=8000/01", bus4.result, bus4.cf, bus4.nf);
        end
    endtask

    task automatic test_zero_and_reserved();
        for (int m = 0; m < 8; m++) run(3'(m), 16'h0000, 0);
        for (int m = 5; m < 8; m++) run(3'(m), 16'hC3A5, 7);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            run(3'($urandom_range(0, 4)), 16'($urandom), int'($urandom_range(1, 15)));
    endtask

    task automatic test_stall();
        int edges;
        @(negedge clock);
        start = 1'b1; mode = 3'd3; data_in = 16'h8001; amount = 4'd1;
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        start = 1'b0; enable = 1'b0;
        repeat (3) begin @(posedge clock); edges++; end
        @(negedge clock);
        checks++;
        if ({bus1.busy, bus1.done} !== 2'b10) begin
            failures++;
            $display("FAIL stall_hold got=%b%b exp=10", bus1.busy, bus1.done);
        end
        enable = 1'b1; start = 1'b1; mode = 3'd0; data_in = 16'hFFFF; amount = 4'd3;
        @(posedge clock);
        edges++;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if ({bus1.done, bus1.result, bus1.cf} !== {1'b1, 16'h0003, 1'b1} || edges != 5) begin
            failures++;
            $display("FAIL stall_rol got=%b/%h/%b lat=%0d exp=1/0003/1 lat=5",
                     bus1.done, bus1.result, bus1.cf, edges);
        end
        repeat (4) @(negedge clock);
        checks++;
        if ({bus1.busy, bus1.done, bus1.result} !== {2'b00, 16'h0003}) begin
            failures++;
            $display("FAIL start_while_busy_ignored got=%b%b/%h exp=00/0003",
                     bus1.busy, bus1.done, bus1.result);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pattern;
        @(negedge clock);
        start = 1'b1; mode = 3'd0; data_in = 16'h0003; amount = 4'd2;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            @(negedge clock);
            pattern[i] = bus1.done;
        end
        start = 1'b0;
        checks++;
        if (pattern !== 8'b0100_0100 || bus1.result !== 16'h000C) begin
            failures++;
            $display("FAIL back_to_back got=%b/%h exp=01000100/000c", pattern, bus1.result);
        end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_reset_mid_shift();
        @(negedge clock);
        start = 1'b1; mode = 3'd1; data_in = 16'hFFFF; amount = 4'd10;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus1.busy, bus1.done, bus1.result, bus1.cf} !== '0) begin
            failures++;
            $display("FAIL reset_mid_shift got=%b%b/%h/%b exp=00/0000/0",
                     bus1.busy, bus1.done, bus1.result, bus1.cf);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL no_done_after_abort got=%b exp=0", bus1.done);
        end
        reset = 1'b1;
        run(3'd1, 16'hFFFF, 10);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_and_reserved();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid_shift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
